ni_flit_injector: RTL and testbench

- Read side of the NI injection FIFO: drains 64-bit words from the FIFO and frames them into typed flits for the router local input port.
- The first word of each packet is a header carrying the payload length. The block tags each outgoing flit as HEAD, BODY, TAIL or HEAD_TAIL.
- Sits between the NI FIFO (read_en/data_out/empty side) and the router local port, which uses a valid/ready handshake.

---
 rtl/noc_pkg.sv | 17 +
 rtl/flit_skid_buf.sv | 53 +++++
 rtl/ni_flit_injector.sv | 111 +++++++++++
 tb/tb_ni_flit_injector.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC flit type encodings, header field layout and widths
package noc_pkg;

  localparam int NOC_DATA_W = 64;
  localparam int FLIT_W     = NOC_DATA_W + 2;

  localparam logic [1:0] FLIT_BODY      = 2'b00;
  localparam logic [1:0] FLIT_HEAD      = 2'b01;
  localparam logic [1:0] FLIT_TAIL      = 2'b10;
  localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_DX_LSB  = 8;
  localparam int HDR_DY_LSB  = 16;
  localparam int HDR_FIELD_W = 8;

endpackage

// File: rtl/flit_skid_buf.sv
// rtl/flit_skid_buf.sv - 2-entry valid/ready flit buffer with occupancy output
module flit_skid_buf #(
  parameter int W = 66
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_data_o,
  output logic         valid_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   occ_q;
  logic         push_ok;
  logic         pop_ok;

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i && (occ_q != 2'd0);
  assign push_ok = push_i && ((occ_q != 2'd2) || pop_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign valid_o     = (occ_q != 2'd0);
  assign occ_o       = occ_q;

endmodule

// File: rtl/ni_flit_injector.sv
// rtl/ni_flit_injector.sv - drains NI FIFO words and frames them into typed flits
module ni_flit_injector
  import noc_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              fifo_read_en,
  input  logic [DATA_W-1:0] fifo_data_out,
  input  logic              fifo_empty,
  output logic [DATA_W+1:0] flit_out,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic              busy,
  output logic              len_err,
  output logic [CNT_W-1:0]  pkt_count
);

  localparam int         REM_W     = $clog2(MAX_LEN + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  logic             inflight_q;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             len_err_q, len_err_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  logic [1:0] occ;
  logic       pop;
  logic [2:0] occ_next;
  logic [1:0] cap_type;
  logic [7:0] hdr_len;

  assign pop      = flit_valid && flit_ready;
  assign occ_next = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  // Only pop when the word landing next cycle is guaranteed a buffer slot.
  assign fifo_read_en = reset && !fifo_empty && (occ_next < 3'd2);
  assign hdr_len      = fifo_data_out[HDR_LEN_LSB +: HDR_FIELD_W];

  always_comb begin
    cap_type  = FLIT_BODY;
    rem_d     = rem_q;
    busy_d    = busy_q;
    len_err_d = 1'b0;
    pkt_cnt_d = pkt_cnt_q;

    if (pop && flit_out[DATA_W+1]) begin
      pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
    end
    if (pop && (flit_out[DATA_W+1:DATA_W] == FLIT_TAIL)) begin
      busy_d = 1'b0;
    end

    if (rem_q == '0) begin
      if (hdr_len == 8'd0) begin
        cap_type = FLIT_HEAD_TAIL;
      end else begin
        cap_type = FLIT_HEAD;
        if (inflight_q) begin
          rem_d  = (hdr_len > MAX_LEN_B) ? REM_W'(MAX_LEN) : REM_W'(hdr_len);
          busy_d = 1'b1;
        end
      end
      if (inflight_q && (hdr_len > MAX_LEN_B)) begin
        len_err_d = 1'b1;
      end
    end else begin
      cap_type = (rem_q == REM_W'(1)) ? FLIT_TAIL : FLIT_BODY;
      if (inflight_q) begin
        rem_d = rem_q - REM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      len_err_q  <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      inflight_q <= fifo_read_en;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      len_err_q  <= len_err_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  flit_skid_buf #(
    .W (DATA_W + 2)
  ) u_skid (
    .clk_i       (clk),
    .rst_ni      (reset),
    .push_i      (inflight_q),
    .push_data_i ({cap_type, fifo_data_out}),
    .pop_i       (pop),
    .head_data_o (flit_out),
    .valid_o     (flit_valid),
    .occ_o       (occ)
  );

  assign busy      = busy_q;
  assign len_err   = len_err_q;
  assign pkt_count = pkt_cnt_q;

endmodule

// File: tb/tb_ni_flit_injector.sv
// tb/tb_ni_flit_injector.sv - directed self-checking bench for ni_flit_injector
module tb_ni_flit_injector;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fifo_read_en;
  logic [63:0] fifo_data_out = '0;
  logic        fifo_empty;
  logic [65:0] flit_out;
  logic        flit_valid;
  logic        flit_ready = 1'b1;
  logic        busy;
  logic        len_err;
  logic [15:0] pkt_count;

  always #5 clk = ~clk;

  ni_flit_injector dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_read_en  (fifo_read_en),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .flit_out      (flit_out),
    .flit_valid    (flit_valid),
    .flit_ready    (flit_ready),
    .busy          (busy),
    .len_err       (len_err),
    .pkt_count     (pkt_count)
  );

  // FIFO model: one-cycle read latency
  logic [63:0] fmem [256];
  int          wr_idx = 0;
  int          rd_idx = 0;
  logic        rd_req = 1'b0;

  assign fifo_empty = (rd_idx == wr_idx);

  always @(negedge clk) rd_req = fifo_read_en;

  always @(posedge clk) begin
    if (rd_req) begin
      fifo_data_out <= fmem[rd_idx[7:0]];
      rd_idx        <= rd_idx + 1;
    end
  end

  // Monitor, sampled on the falling edge
  int          cyc = 0;
  int          n_pops = 0;
  int          n_busy = 0;
  int          n_lerr = 0;
  int          n_unstable = 0;
  logic        prev_stall = 1'b0;
  logic [65:0] prev_flit = '0;
  logic [65:0] rx [$];
  int          rx_cyc [$];
  int          pop_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_read_en) begin
      n_pops = n_pops + 1;
      pop_cyc.push_back(cyc);
    end
    if (busy) n_busy = n_busy + 1;
    if (len_err) n_lerr = n_lerr + 1;
    if (flit_valid && flit_ready) begin
      rx.push_back(flit_out);
      rx_cyc.push_back(cyc);
    end
    if (prev_stall && (!flit_valid || (flit_out != prev_flit))) n_unstable = n_unstable + 1;
    prev_stall = flit_valid && !flit_ready;
    prev_flit  = flit_out;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] w);
    fmem[wr_idx[7:0]] = w;
    wr_idx = wr_idx + 1;
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    for (int i = 0; (i < budget) && (rx.size() < n); i++) sample();
    check(tag, 66'(rx.size() >= n), 66'd1);
  endtask

  localparam logic [63:0] W1 = 64'h0000_0000_0003_0200;
  localparam logic [63:0] H3 = 64'h0000_0000_0001_0202;
  localparam logic [63:0] A3 = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] B3 = 64'h35A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] H4 = 64'h0000_0000_0004_0304;
  localparam logic [63:0] H5 = 64'h0000_0000_0000_0014;
  localparam logic [63:0] H6 = 64'h0000_0000_0000_0500;
  localparam logic [63:0] H7 = 64'h0000_0000_0000_0004;
  localparam logic [63:0] E0 = 64'hE0E0_E0E0_E0E0_E0E0;
  localparam logic [63:0] H8 = 64'h0000_0000_0007_0600;

  initial begin
    int rb;
    int bb;
    int pb;
    int lb;
    logic [63:0] w;

    // Reset with a non-empty FIFO
    load(W1);
    repeat (3) sample();
    check("rst_read_en", 66'(fifo_read_en), 66'd0);
    check("rst_valid", 66'(flit_valid), 66'd0);
    check("rst_pkt_count", 66'(pkt_count), 66'd0);
    check("rst_busy", 66'(busy), 66'd0);
    check("rst_len_err", 66'(len_err), 66'd0);
    drive();
    reset = 1'b1;
    sample();
    check("rel_read_en", 66'(fifo_read_en), 66'd1);
    sample();
    check("rel_popped", 66'(rd_idx), 66'd1);

    // Single-flit packet
    wait_rx("single_done", 1, 20);
    check("single_flit", rx[0], {2'b11, W1});
    check("single_latency", 66'(rx_cyc[0] - pop_cyc[0]), 66'd2);
    repeat (2) sample();
    check("single_pkt_count", 66'(pkt_count), 66'd1);
    check("single_no_busy", 66'(n_busy), 66'd0);

    // 3-word packet at full rate
    drive();
    rb = rx.size();
    bb = n_busy;
    load(H3);
    load(A3);
    load(B3);
    wait_rx("three_done", rb + 3, 30);
    check("three_head", rx[rb], {2'b01, H3});
    check("three_body", rx[rb+1], {2'b00, A3});
    check("three_tail", rx[rb+2], {2'b10, B3});
    check("three_back_to_back", 66'(rx_cyc[rb+2] - rx_cyc[rb]), 66'd2);
    repeat (2) sample();
    check("three_busy_cycles", 66'(n_busy - bb), 66'd3);
    check("three_busy_clear", 66'(busy), 66'd0);
    check("three_pkt_count", 66'(pkt_count), 66'd2);

    // Backpressure on a 5-word packet
    drive();
    flit_ready = 1'b0;
    rb = rx.size();
    pb = n_pops;
    load(H4);
    for (int i = 1; i <= 4; i++) load(64'hD000_0000_0000_0000 + 64'(i));
    repeat (10) sample();
    check("bp_pops", 66'(n_pops - pb), 66'd2);
    check("bp_valid", 66'(flit_valid), 66'd1);
    check("bp_head_held", flit_out, {2'b01, H4});
    check("bp_read_en_low", 66'(fifo_read_en), 66'd0);
    check("bp_stable", 66'(n_unstable), 66'd0);
    drive();
    flit_ready = 1'b1;
    wait_rx("bp_done", rb + 5, 30);
    check("bp_flit0", rx[rb], {2'b01, H4});
    for (int i = 1; i <= 3; i++) check("bp_body", rx[rb+i], {2'b00, 64'hD000_0000_0000_0000 + 64'(i)});
    check("bp_tail", rx[rb+4], {2'b10, 64'hD000_0000_0000_0004});
    check("bp_back_to_back", 66'(rx_cyc[rb+4] - rx_cyc[rb]), 66'd4);
    repeat (2) sample();
    check("bp_pkt_count", 66'(pkt_count), 66'd3);

    // Length clamp: LEN=20 carries 16 payload words, then a LEN=0 header
    drive();
    rb = rx.size();
    lb = n_lerr;
    load(H5);
    for (int i = 1; i <= 16; i++) load(64'hC000_0000_0000_0000 + 64'(i));
    load(H6);
    wait_rx("clamp_done", rb + 18, 60);
    check("clamp_head", rx[rb], {2'b01, H5});
    for (int i = 1; i <= 15; i++) check("clamp_body", rx[rb+i], {2'b00, 64'hC000_0000_0000_0000 + 64'(i)});
    check("clamp_tail", rx[rb+16], {2'b10, 64'hC000_0000_0000_0010});
    check("clamp_next_hdr", rx[rb+17], {2'b11, H6});
    repeat (2) sample();
    check("clamp_len_err_once", 66'(n_lerr - lb), 66'd1);
    check("clamp_pkt_count", 66'(pkt_count), 66'd5);

    // Reset mid-packet after HEAD and one BODY of a LEN=4 packet
    drive();
    rb = rx.size();
    load(H7);
    load(E0);
    wait_rx("mid_partial", rb + 2, 20);
    check("mid_head", rx[rb], {2'b01, H7});
    check("mid_body", rx[rb+1], {2'b00, E0});
    sample();
    check("mid_busy_before", 66'(busy), 66'd1);
    drive();
    reset = 1'b0;
    sample();
    check("mid_rst_busy", 66'(busy), 66'd0);
    check("mid_rst_pkt_count", 66'(pkt_count), 66'd0);
    check("mid_rst_valid", 66'(flit_valid), 66'd0);
    drive();
    reset = 1'b1;
    drive();
    w = H8;
    load(w);
    wait_rx("mid_next_done", rb + 3, 20);
    check("mid_next_hdr", rx[rb+2], {2'b11, H8});
    repeat (2) sample();
    check("mid_pkt_count", 66'(pkt_count), 66'd1);
    check("mid_busy_after", 66'(busy), 66'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
